// File: rtl/adc_serial_rx.sv
// Serial ADC word receiver: synchronizes SCK/CSLD/SDOUT, deserializes 16-bit MSB-first frames
// and queues completed words. Define ADC_SERIAL_RX_FIFO_EN for a 4-deep queue; default is one holding register.
module adc_serial_rx (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCK,
  input  logic        CSLD,
  input  logic        SDOUT,
  output logic [15:0] DATA,
  output logic        VALID,
  input  logic        READY,
  output logic [2:0]  LEVEL,
  output logic        OVF,
  output logic        FRAME_ERR
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q;
  logic [2:0]  sck_q;
  logic [2:0]  csld_q;
  logic [1:0]  sdo_q;
  logic [3:0]  cnt_q;
  logic [15:0] sreg_q;
  logic        push_q;
  logic        ferr_q;
  logic        ovf_q;
  logic [1:0]  settle_q;
  logic        armed_q;

  logic sck_rise, csld_fall, csld_rise, pop, accept;

  assign sck_rise  =  sck_q[1]  & ~sck_q[2];
  assign csld_fall = ~csld_q[1] &  csld_q[2];
  assign csld_rise =  csld_q[1] & ~csld_q[2];

  // Synchronizers reset to the idle pin levels, so a frame strobe already low when reset
  // releases would look like a fresh fall; armed_q waits for CSLD to be seen high first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      sck_q    <= '1;
      csld_q   <= '1;
      sdo_q    <= '0;
      cnt_q    <= '0;
      sreg_q   <= '0;
      push_q   <= 1'b0;
      ferr_q   <= 1'b0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], SCK};
      csld_q <= {csld_q[1:0], CSLD};
      sdo_q  <= {sdo_q[0], SDOUT};
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd3 && csld_q[1]) armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (armed_q && csld_fall) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            sreg_q  <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            sreg_q <= {sreg_q[14:0], sdo_q[1]};
            cnt_q  <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q <= DONE;
              push_q  <= 1'b1;
            end else if (csld_rise) begin
              state_q <= IDLE;
              ferr_q  <= 1'b1;
            end
          end else if (csld_rise) begin
            state_q <= IDLE;
            ferr_q  <= 1'b1;
          end
        end
        DONE: begin
          // Level test also covers a CSLD rise that coincided with the final SCK rise.
          if (csld_q[1]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pop       = VALID & READY;
  assign VALID     = (LEVEL != 3'd0);
  assign OVF       = ovf_q;
  assign FRAME_ERR = ferr_q;

`ifdef ADC_SERIAL_RX_FIFO_EN
  logic [15:0] mem_q [4];
  logic [1:0]  wr_q, rd_q;
  logic [2:0]  lvl_q, lvl_d;
  logic        full;

  assign full   = (lvl_q == 3'd4);
  assign accept = push_q & (~full | pop);

  always_comb begin
    lvl_d = lvl_q;
    if (accept && !pop)      lvl_d = lvl_q + 3'd1;
    else if (!accept && pop) lvl_d = lvl_q - 3'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_q] <= sreg_q;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      lvl_q <= lvl_d;
      ovf_q <= push_q & ~accept;
    end
  end

  assign DATA  = mem_q[rd_q];
  assign LEVEL = lvl_q;
`else
  logic [15:0] hold_q;
  logic        full_q, full_d;

  assign accept = push_q & (~full_q | pop);

  always_comb begin
    full_d = full_q;
    if (accept)   full_d = 1'b1;
    else if (pop) full_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) hold_q <= sreg_q;
      full_q <= full_d;
      ovf_q  <= push_q & ~accept;
    end
  end

  assign DATA  = hold_q;
  assign LEVEL = {2'b00, full_q};
`endif

endmodule

// File: doc/adc_serial_rx.md
ADC_SERIAL_RX -- requirements
Module: adc_serial_rx

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port SCK, input, 1 bit: serial clock from the ADC/DAC serializer; data is valid at its rising edge.
REQ-004 SHALL have port CSLD, input, 1 bit: active-low frame strobe from the serializer.
REQ-005 SHALL have port SDOUT, input, 1 bit: serial data from the ADC, MSB first.
REQ-006 SHALL have port DATA, output, 16 bits: head-of-queue sample word.
REQ-007 SHALL have port VALID, output, 1 bit: DATA holds a valid word.
REQ-008 SHALL have port READY, input, 1 bit: consumer accepts DATA this cycle.
REQ-009 SHALL have port LEVEL, output, 3 bits: number of words queued.
REQ-010 SHALL have port OVF, output, 1 bit: one-cycle pulse when a completed word is dropped.
REQ-011 SHALL have port FRAME_ERR, output, 1 bit: one-cycle pulse when a frame ends before 16 bits.

Function
REQ-012 SHALL pass SCK, CSLD and SDOUT each through a 2-flop synchronizer, then detect edges by comparing against one further delayed copy.
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE: on a synchronized CSLD falling edge SHALL go to SHIFT with bit counter = 0 and shift register cleared.
REQ-015 SHIFT: on each synchronized SCK rising edge SHALL shift synchronized SDOUT into bit 0 (left shift) and increment the 4-bit counter.
REQ-016 SHIFT: on the 16th SCK rise SHALL go to DONE; the push occurs in the DONE entry cycle.
REQ-017 SHIFT: a synchronized CSLD rising edge before 16 bits SHALL pulse FRAME_ERR for 1 cycle, discard the partial word and return to IDLE.
REQ-018 DONE: SHALL ignore further SCK edges and return to IDLE on a synchronized CSLD rising edge.
REQ-019 Simultaneous CSLD rise and 16th SCK rise in SHIFT SHALL count as a complete word, with no FRAME_ERR.
REQ-020 Queue SHALL be 4 deep, first in first out; VALID = (LEVEL != 0); DATA = oldest word.
REQ-021 A pop SHALL occur when VALID and READY are both high; DATA and VALID SHALL hold stable while VALID=1 and READY=0.
REQ-022 Push into a full queue SHALL drop the new word, pulse OVF for 1 cycle and leave the contents unchanged.
REQ-023 Push and pop in the same cycle when full SHALL accept both with no OVF; LEVEL stays 4.
REQ-024 Push and pop in the same cycle when empty SHALL NOT occur: VALID is low, so there is no pop.
REQ-025 Read and write pointers SHALL be 2 bits and wrap modulo 4.
REQ-026 Latency from the 16th SCK rise at the pin to VALID=1 (queue empty) SHALL be exactly 4 CLK cycles.

Reset
REQ-027 RST=1 at a rising CLK edge SHALL set FSM=IDLE, counter=0, shift register=0, pointers=0, LEVEL=0, VALID=0, DATA=0, OVF=0, FRAME_ERR=0, and all synchronizer flops to 1 (SCK and CSLD idle high), SDOUT flops to 0.
REQ-028 RST asserted mid-frame SHALL discard the partial word; after release, the next word SHALL be captured only after a fresh CSLD falling edge.

Configuration
REQ-029 Macro ADC_SERIAL_RX_FIFO_EN defined: the queue SHALL be the 4-deep queue of REQ-020..025.
REQ-030 Macro ADC_SERIAL_RX_FIFO_EN undefined: the queue SHALL be a single holding register, LEVEL in {0,1}, and full means LEVEL=1; OVF, latency and handshake rules are otherwise unchanged.

Verification
REQ-031 SCK period 256 CLK, CSLD low for 16 SCK rises, SDOUT = 0xA5C3 MSB first, READY=1 -> DATA=0xA5C3, VALID high exactly 1 cycle, 4 cycles after the 16th rise.
REQ-032 CSLD rises after 9 SCK rises -> FRAME_ERR one-cycle pulse, LEVEL stays 0; the next full frame 0x1234 is received correctly.
REQ-033 READY=0, 5 frames 0x0001..0x0005 -> LEVEL=4, OVF pulses on the 5th frame; draining then yields 0x0001..0x0004 in order (without the macro: LEVEL=1, OVF on frames 2..5, yields 0x0001).
REQ-034 Queue full, READY=1 in the exact cycle of a push -> no OVF, LEVEL remains 4, the new word becomes the tail.
REQ-035 RST pulsed for 1 cycle after 8 bits of frame 0xFFFF -> no word, no FRAME_ERR; the following frame 0x8001 is received intact.
